key_event_decoder: RTL and testbench

//  Downstream consumer of the edge-detection stage. Takes one-cycle press/release

---
 rtl/key_event_decoder_if.sv | 18 +
 rtl/key_event_decoder.sv | 81 ++++++++
 tb/tb_key_event_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: press/release flags in, gesture event pulses and status levels out.
interface key_event_decoder_if;
  logic press_flag;
  logic release_flag;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic hold;
  logic busy;
  modport master (
    output press_flag, release_flag,
    input  short_pulse, long_pulse, double_pulse, hold, busy
  );
  modport slave (
    input  press_flag, release_flag,
    output short_pulse, long_pulse, double_pulse, hold, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short, long and double-click pulses.
module key_event_decoder #(
  parameter int LONG_CYC    = 50_000_000,
  parameter int DBL_GAP_CYC = 15_000_000,
  parameter int CNT_W       = 26
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  key_event_decoder_if.slave kif
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE:    state_d = (kif.press_flag && !kif.release_flag) ? PRESS1 : IDLE;
      PRESS1: begin
        // release takes priority over reaching the long threshold
        if (kif.release_flag) state_d = WAIT2;
        else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (kif.press_flag) state_d = PRESS2;
        else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (kif.release_flag) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG:    state_d = kif.release_flag ? IDLE : LONG;
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d != state_q) ? '0 :
             (state_q == PRESS1 || state_q == WAIT2) ? cnt_q + 1'b1 : cnt_q;
    hold_d = (state_d == LONG);
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
    end
  end
  assign kif.short_pulse  = short_q;
  assign kif.long_pulse   = long_q;
  assign kif.double_pulse = double_q;
  assign kif.hold         = hold_q;
  assign kif.busy         = busy_q;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture scenarios plus random flags, checked against a timestamp model.
module tb_key_event_decoder;
  localparam int LONG = 20;
  localparam int DBL  = 10;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  key_event_decoder_if kif ();
  key_event_decoder #(.LONG_CYC(LONG), .DBL_GAP_CYC(DBL), .CNT_W(5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .kif(kif.slave)
  );
  always #5 sys_clk = ~sys_clk;
  int n = 0, base = 0, total = 0, passed = 0;
  // gesture model: active/long flags plus timestamps of first press, release, second press
  bit act = 0, lng = 0, e_short = 0, e_long = 0, e_double = 0;
  int p1 = -1, r1 = -1, p2 = -1;
  int m_short = -1, m_long = -1, m_double = -1;
  int d_short = -1, d_long = -1, d_double = -1;
  task automatic check(input string nm, input int act_v, input int exp_v);
    total++;
    if (act_v == exp_v) passed++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, n - base, act_v, exp_v);
  endtask
  task automatic model_reset();
    act = 0; lng = 0; e_short = 0; e_long = 0; e_double = 0;
  endtask
  task automatic model_step(input bit pf, input bit rf);
    e_short = 0; e_long = 0; e_double = 0;
    if (!act) begin
      if (pf && !rf) begin act = 1; lng = 0; p1 = n; r1 = -1; p2 = -1; end
    end else if (lng) begin
      if (rf) act = 0;
    end else if (r1 < 0) begin
      if (rf) r1 = n;
      else if (n - p1 == LONG) begin lng = 1; e_long = 1; end
    end else if (p2 < 0) begin
      if (pf) p2 = n;
      else if (n - r1 == DBL) begin act = 0; e_short = 1; end
    end else if (rf) begin
      act = 0; e_double = 1;
    end
    if (e_short  && m_short  < 0) m_short  = n + 1 - base;
    if (e_long   && m_long   < 0) m_long   = n + 1 - base;
    if (e_double && m_double < 0) m_double = n + 1 - base;
  endtask
  task automatic cyc(input bit pf, input bit rf);
    kif.press_flag = pf;
    kif.release_flag = rf;
    @(posedge sys_clk);
    if (sys_rst_n) model_step(pf, rf);
    n++;
    #1;
  endtask
  task automatic start_scn();
    base = n;
    m_short = -1; m_long = -1; m_double = -1;
    d_short = -1; d_long = -1; d_double = -1;
  endtask
  task automatic scenario(input int pa, input int ra, input int pb, input int rb, input int len);
    start_scn();
    for (int i = 0; i < len; i++) cyc(i == pa || i == pb, i == ra || i == rb);
  endtask
  task automatic pin(input string nm, input int ms, input int ml, input int md);
    check({nm, "_model_short"}, m_short, ms);
    check({nm, "_model_long"}, m_long, ml);
    check({nm, "_model_double"}, m_double, md);
    check({nm, "_dut_short"}, d_short, ms);
    check({nm, "_dut_long"}, d_long, ml);
    check({nm, "_dut_double"}, d_double, md);
  endtask
  always @(negedge sys_clk) begin
    check("short_pulse", int'(kif.short_pulse), int'(e_short && act == 0 && sys_rst_n));
    check("long_pulse", int'(kif.long_pulse), int'(e_long && sys_rst_n));
    check("double_pulse", int'(kif.double_pulse), int'(e_double && sys_rst_n));
    check("hold", int'(kif.hold), int'(act && lng));
    check("busy", int'(kif.busy), int'(act));
    if (kif.short_pulse  && d_short  < 0) d_short  = n - base;
    if (kif.long_pulse   && d_long   < 0) d_long   = n - base;
    if (kif.double_pulse && d_double < 0) d_double = n - base;
  end
  initial begin
    kif.press_flag = 1'b0;
    kif.release_flag = 1'b0;
    model_reset();
    repeat (3) cyc(0, 0);
    sys_rst_n = 1'b1;
    repeat (2) cyc(0, 0);
    scenario(0, 5, -1, -1, 40);
    pin("t1", 16, -1, -1);
    scenario(0, 40, -1, -1, 50);
    pin("t2", -1, 21, -1);
    scenario(0, 3, 8, 12, 30);
    pin("t3", -1, -1, 13);
    scenario(0, 3, 14, 16, 40);
    pin("t4", 14, -1, -1);
    scenario(0, 20, -1, -1, 40);
    pin("t5", 31, -1, -1);
    start_scn();
    cyc(1, 0);
    repeat (4) cyc(0, 0);
    sys_rst_n = 1'b0;
    model_reset();
    cyc(0, 0);
    check("t6_busy_in_reset", int'(kif.busy), 0);
    cyc(0, 0);
    sys_rst_n = 1'b1;
    cyc(0, 0);
    cyc(0, 1);
    repeat (40) cyc(0, 0);
    pin("t6", -1, -1, -1);
    start_scn();
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r == 0) begin
        sys_rst_n = 1'b0;
        model_reset();
        cyc(0, 0);
        cyc(0, 0);
        sys_rst_n = 1'b1;
      end else if (r < 80) cyc(1, 0);
      else if (r < 160) cyc(0, 1);
      else if (r < 170) cyc(1, 1);
      else cyc(0, 0);
    end
    repeat (2) cyc(0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
